// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite constants, slave FSM states and the byte-lane helper.
// Imported by the SRAM slave top and its byte-lane memory.
package ahb_lite_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   localparam logic [2:0] HSIZE_BYTE  = 3'd0;
   localparam logic [2:0] HSIZE_HALF  = 3'd1;
   localparam logic [2:0] HSIZE_WORD  = 3'd2;
   localparam logic [2:0] HSIZE_DWORD = 3'd3;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ERR1,
      ERR2
   } ahb_slv_state_t;

   // Lanes touched by an aligned beat; bit i = byte lane i of the bus.
   function automatic logic [7:0] byte_lane_mask(
      input logic [2:0] addr,
      input logic [2:0] size,
      input int         dw
   );
      logic [15:0] m;
      int unsigned nb;
      int unsigned off;
      nb  = 32'd1 << size;
      off = 32'(addr) % (32'(dw) / 32'd8);
      m   = 16'((32'd1 << nb) - 32'd1) << off;
      return m[7:0];
   endfunction

endpackage

// File: rtl/ahb_sram_bytemem.sv
// Word-organised SRAM array with per-byte write strobes,
// one synchronous write port and one combinational read port.
module ahb_sram_bytemem #(
   parameter  int DW = 32,
   parameter  int MS = 4096,
   localparam int NB = DW / 8,
   localparam int NW = MS / NB,
   localparam int IW = (NW > 1) ? $clog2(NW) : 1
) (
   input  logic          clk,
   input  logic          we,
   input  logic [NB-1:0] wstrb,
   input  logic [IW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [IW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem_q [NW];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < NB; i++) begin
            if (wstrb[i]) begin
               mem_q[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
         end
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: wait states, read-only window, two-cycle ERROR.
// Define AHB_SLV_RAND_WAIT_EN to add 0..3 LFSR-driven extra wait states.
module ahb_lite_sram_slave
   import ahb_lite_pkg::*;
#(
   parameter int unsigned AW        = 32,
   parameter int unsigned DW        = 32,
   parameter int unsigned MS        = 4096,
   parameter int unsigned RO_BASE   = 0,
   parameter int unsigned RO_SIZE   = 0,
   parameter int unsigned LW_NS     = 0,
   parameter int unsigned LW_S      = 0,
   parameter int unsigned LR_NS     = 0,
   parameter int unsigned LR_S      = 0,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic          hclk,
   input  logic          hreset,
   input  logic          hsel,
   input  logic [AW-1:0] haddr,
   input  logic [1:0]    htrans,
   input  logic          hwrite,
   input  logic [2:0]    hsize,
   input  logic [2:0]    hburst,
   input  logic [3:0]    hprot,
   input  logic [DW-1:0] hwdata,
   input  logic          hreadyin,
   input  logic          err_inj,
   output logic [DW-1:0] hrdata,
   output logic          hreadyout,
   output logic          hresp
);

   localparam int NB = int'(DW / 8);
   localparam int LB = $clog2(NB);
   localparam int NW = int'(MS) / NB;
   localparam int IW = (NW > 1) ? $clog2(NW) : 1;

   ahb_slv_state_t state_q, state_d;
   logic [31:0]    cnt_q, cnt_d;
   logic           dph_q, dph_d;
   logic [AW-1:0]  addr_q, addr_d;
   logic [2:0]     size_q, size_d;
   logic           write_q, write_d;

   logic        rdy;
   logic        take;
   logic        addr_err;
   logic [31:0] lat_base;
   logic [31:0] lat;
   logic        done;
   logic        mem_we;
   logic [7:0]  lane8;
   logic [NB-1:0] wstrb;
   logic [IW-1:0] mem_idx;
   logic [DW-1:0] rdata;
   logic [DW-1:0] rd_mask;

   assign rdy  = (state_q == IDLE) || (state_q == ERR2);
   assign take = hsel & hreadyin & htrans[1] & rdy;

   always_comb begin
      int unsigned nb;
      logic [63:0] a;
      nb = 32'd1 << hsize;
      a  = 64'(haddr);
      addr_err = err_inj;
      if (a >= 64'(MS))                       addr_err = 1'b1;
      if ((a & (64'(nb) - 64'd1)) != 64'd0)   addr_err = 1'b1;
      if (nb > 32'(NB))                       addr_err = 1'b1;
      if (hwrite && a >= 64'(RO_BASE) &&
          a < 64'(RO_BASE) + 64'(RO_SIZE))    addr_err = 1'b1;
   end

   always_comb begin
      lat_base = LR_NS;
      unique case ({hwrite, htrans[0]})
         2'b00: lat_base = LR_NS;
         2'b01: lat_base = LR_S;
         2'b10: lat_base = LW_NS;
         2'b11: lat_base = LW_S;
         default: lat_base = LR_NS;
      endcase
   end

`ifdef AHB_SLV_RAND_WAIT_EN
   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (take) begin
         lfsr_d = {lfsr_q[14:0],
                   lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end
   end

   always_ff @(posedge hclk) begin
      if (hreset) lfsr_q <= LFSR_SEED;
      else        lfsr_q <= lfsr_d;
   end

   assign lat = lat_base + {30'd0, lfsr_q[1:0]};
`else
   logic [15:0] unused_seed;
   assign unused_seed = LFSR_SEED;
   assign lat = lat_base;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dph_d   = dph_q;
      addr_d  = addr_q;
      size_d  = size_q;
      write_d = write_q;
      unique case (state_q)
         IDLE, ERR2: begin
            state_d = IDLE;
            dph_d   = 1'b0;
            if (take) begin
               addr_d  = haddr;
               size_d  = hsize;
               write_d = hwrite;
               if (addr_err) begin
                  state_d = ERR1;
               end else begin
                  dph_d = 1'b1;
                  if (lat != 32'd0) begin
                     state_d = WAIT;
                     cnt_d   = lat - 32'd1;
                  end
               end
            end
         end
         WAIT: begin
            if (cnt_q == 32'd0) state_d = IDLE;
            else                cnt_d   = cnt_q - 32'd1;
         end
         ERR1: state_d = ERR2;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dph_q   <= 1'b0;
         addr_q  <= '0;
         size_q  <= '0;
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dph_q   <= dph_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         write_q <= write_d;
      end
   end

   // The data phase ends on a ready cycle of a non-error transfer.
   assign done    = (state_q == IDLE) && dph_q;
   assign mem_we  = done && write_q && !hreset;
   assign lane8   = byte_lane_mask(addr_q[2:0], size_q, int'(DW));
   assign wstrb   = lane8[NB-1:0];
   assign mem_idx = IW'(addr_q >> LB);

   ahb_sram_bytemem #(
      .DW (int'(DW)),
      .MS (int'(MS))
   ) u_mem (
      .clk   (hclk),
      .we    (mem_we),
      .wstrb (wstrb),
      .waddr (mem_idx),
      .wdata (hwdata),
      .raddr (mem_idx),
      .rdata (rdata)
   );

   always_comb begin
      rd_mask = '0;
      for (int i = 0; i < NB; i++) begin
         rd_mask[i*8 +: 8] = {8{wstrb[i]}};
      end
   end

   assign hrdata    = (done && !write_q) ? (rdata & rd_mask) : '0;
   assign hreadyout = rdy;
   assign hresp     = (state_q == ERR1 || state_q == ERR2) ?
                      HRESP_ERROR : HRESP_OKAY;

   logic unused_ok;
   assign unused_ok = ^{hburst, hprot, lane8};

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Random and directed AHB-Lite traffic against a byte-array model.
// Checks wait counts, responses, read data and mid-transfer reset.
module tb_ahb_lite_sram_slave;
   import ahb_lite_pkg::*;

   localparam int unsigned MS      = 4096;
   localparam int unsigned RO_BASE = 32'h100;
   localparam int unsigned RO_SIZE = 32'h100;
   localparam int unsigned LW_NS   = 0;
   localparam int unsigned LW_S    = 3;
   localparam int unsigned LR_NS   = 2;
   localparam int unsigned LR_S    = 1;

   logic        hclk = 1'b0;
   logic        hreset = 1'b1;
   logic        hsel = 1'b0;
   logic [31:0] haddr = '0;
   logic [1:0]  htrans = HTRANS_IDLE;
   logic        hwrite = 1'b0;
   logic [2:0]  hsize = '0;
   logic [2:0]  hburst = '0;
   logic [3:0]  hprot = '0;
   logic [31:0] hwdata = '0;
   logic        hreadyin;
   logic        err_inj = 1'b0;
   logic [31:0] hrdata;
   logic        hreadyout;
   logic        hresp;

   always #5 hclk = ~hclk;

   // Single-slave bus: HREADY is this slave's own ready.
   assign hreadyin = hreadyout;

   ahb_lite_sram_slave #(
      .AW(32), .DW(32), .MS(MS),
      .RO_BASE(RO_BASE), .RO_SIZE(RO_SIZE),
      .LW_NS(LW_NS), .LW_S(LW_S),
      .LR_NS(LR_NS), .LR_S(LR_S),
      .LFSR_SEED(16'hACE1)
   ) dut (
      .hclk(hclk), .hreset(hreset), .hsel(hsel),
      .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
      .hsize(hsize), .hburst(hburst), .hprot(hprot),
      .hwdata(hwdata), .hreadyin(hreadyin),
      .err_inj(err_inj), .hrdata(hrdata),
      .hreadyout(hreadyout), .hresp(hresp)
   );

   typedef struct {
      bit          valid;
      bit          write;
      bit          seq;
      bit          inj;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] data;
   } xfer_t;

   xfer_t q[$];
   xfer_t a_ph;
   xfer_t d_ph;
   logic [7:0] mem_m [MS];
   bit         known_m [MS];
   int         n_chk = 0;
   int         n_pass = 0;
   int         waits = 0;
   int         bad = 0;
   int         n_done = 0;
   bit         prev_rdy = 1'b1;
   logic [31:0] last_rdata = '0;
   int         wlog[$];

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic xfer_t mk(bit v, bit w, bit s, logic [31:0] a,
                                logic [2:0] sz, logic [31:0] d, bit inj);
      xfer_t x;
      x.valid = v; x.write = w; x.seq = s; x.inj = inj;
      x.addr = a; x.size = sz; x.data = d;
      return x;
   endfunction

   function automatic bit is_err(xfer_t x);
      int unsigned nb;
      nb = 32'd1 << x.size;
      return x.inj || x.addr >= MS || (x.addr % nb) != 0 || nb > 4 ||
             (x.write && x.addr >= RO_BASE && x.addr < RO_BASE + RO_SIZE);
   endfunction

   function automatic int unsigned lat_of(xfer_t x);
      if (x.write) return x.seq ? LW_S : LW_NS;
      return x.seq ? LR_S : LR_NS;
   endfunction

   task automatic push(bit w, bit s, logic [31:0] a, logic [2:0] sz,
                       logic [31:0] d, bit inj);
      q.push_back(mk(1'b1, w, s, a, sz, d, inj));
   endtask

   task automatic finish_x();
      bit e;
      int unsigned nb;
      int unsigned ln;
      logic [31:0] exp;
      logic [31:0] km;
      e   = is_err(d_ph);
      nb  = 32'd1 << d_ph.size;
      ln  = d_ph.addr % 4;
      exp = '0;
      km  = '1;
      chk($sformatf("resp@%0h", d_ph.addr), hresp, e);
      chk($sformatf("wait@%0h", d_ph.addr), waits,
          e ? 1 : lat_of(d_ph));
      chk($sformatf("waitcyc@%0h", d_ph.addr), bad, 0);
      if (!e && !d_ph.write) begin
         for (int i = 0; i < nb; i++) begin
            exp[(ln+i)*8 +: 8] = mem_m[d_ph.addr+i];
            if (!known_m[d_ph.addr+i]) km[(ln+i)*8 +: 8] = 8'h00;
         end
      end
      chk($sformatf("rdata@%0h", d_ph.addr), hrdata & km, exp & km);
      if (!e && d_ph.write) begin
         for (int i = 0; i < nb; i++) begin
            mem_m[d_ph.addr+i]   = d_ph.data[(ln+i)*8 +: 8];
            known_m[d_ph.addr+i] = 1'b1;
         end
      end
      last_rdata = hrdata;
      wlog.push_back(waits);
      n_done++;
      d_ph.valid = 1'b0;
   endtask

   task automatic step();
      @(posedge hclk); #1;
      if (prev_rdy) begin
         d_ph  = a_ph;
         waits = 0;
         bad   = 0;
         if (q.size() > 0) a_ph = q.pop_front();
         else a_ph = mk(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
         if (a_ph.valid) begin
            hsel    = 1'b1;
            htrans  = {1'b1, a_ph.seq};
            haddr   = a_ph.addr;
            hwrite  = a_ph.write;
            hsize   = a_ph.size;
            err_inj = a_ph.inj;
         end else begin
            hsel    = 1'($urandom_range(0, 1));
            htrans  = hsel ? 2'($urandom_range(0, 1))
                           : 2'($urandom_range(0, 3));
            haddr   = $urandom();
            hwrite  = 1'($urandom_range(0, 1));
            hsize   = 3'($urandom_range(0, 7));
            err_inj = 1'($urandom_range(0, 1));
         end
         hburst = 3'($urandom_range(0, 7));
         hprot  = 4'($urandom_range(0, 15));
         hwdata = (d_ph.valid && d_ph.write) ? d_ph.data : $urandom();
      end
      @(negedge hclk);
      prev_rdy = hreadyout;
      if (!d_ph.valid) begin
         chk("idle", {hreadyout, hresp, hrdata}, {1'b1, 1'b0, 32'h0});
      end else if (!hreadyout) begin
         waits++;
         if (hresp !== is_err(d_ph) || hrdata !== 32'h0) bad++;
      end else begin
         finish_x();
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q.size() > 0 || a_ph.valid || d_ph.valid) && n < 5000) begin
         step();
         n++;
      end
      if (n >= 5000) chk("drain_timeout", n, 0);
   endtask

   initial begin
      int n0;
      int n;
      logic [31:0] old;
      for (int i = 0; i < MS; i++) known_m[i] = 1'b0;
      a_ph = mk(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
      d_ph = a_ph;

      repeat (3) @(posedge hclk);
      @(negedge hclk);
      chk("reset", {hreadyout, hresp, hrdata}, {1'b1, 1'b0, 32'h0});
      @(posedge hclk); #1;
      hreset = 1'b0;

      // Back-to-back zero-wait word writes fill the test region.
      for (int a = 0; a < 'h100; a += 4) push(1, 0, a, 2, $urandom(), 0);
      for (int a = 'h200; a < 'h400; a += 4) push(1, 0, a, 2, $urandom(), 0);
      n0 = n_done;
      repeat (193) step();
      chk("b2b", n_done - n0, 192);
      drain();

      push(1, 0, 32'h10, HSIZE_WORD, 32'hDEADBEEF, 0);
      push(0, 0, 32'h10, HSIZE_WORD, 32'h0, 0);
      drain();
      chk("t1_rd", last_rdata, 32'hDEADBEEF);

      push(1, 0, 32'h10, HSIZE_WORD, 32'h11223344, 0);
      push(1, 0, 32'h13, HSIZE_BYTE, 32'hA5000000, 0);
      push(0, 0, 32'h10, HSIZE_WORD, 32'h0, 0);
      drain();
      chk("t2_rd", last_rdata, 32'hA5223344);

      wlog.delete();
      push(0, 0, 32'h10, HSIZE_WORD, 32'h0, 0);
      push(0, 1, 32'h14, HSIZE_WORD, 32'h0, 0);
      drain();
      chk("t3_ns", wlog[0], 2);
      chk("t3_s", wlog[1], 1);

      push(1, 0, MS, HSIZE_WORD, 32'h55AA55AA, 0);
      push(1, 0, 32'h1, HSIZE_HALF, 32'h77777777, 0);
      push(1, 0, 32'h20, HSIZE_WORD, 32'h99999999, 1);
      push(0, 0, 32'h0, HSIZE_WORD, 32'h0, 0);
      push(0, 0, 32'h20, HSIZE_WORD, 32'h0, 0);
      drain();

      wlog.delete();
      push(1, 0, 32'h104, HSIZE_WORD, 32'h12345678, 0);
      push(0, 0, 32'h104, HSIZE_WORD, 32'h0, 0);
      drain();
      chk("t5_wr_err", wlog[0], 1);

      // Reset lands while a 3-wait SEQ write is still waiting.
      old = {mem_m['h43], mem_m['h42], mem_m['h41], mem_m['h40]};
      push(1, 1, 32'h40, HSIZE_WORD, ~old, 0);
      n = 0;
      while (!(d_ph.valid && waits == 2) && n < 20) begin
         step();
         n++;
      end
      chk("t6_wait", waits, 2);
      @(posedge hclk); #1;
      hreset = 1'b1;
      hsel   = 1'b0;
      htrans = HTRANS_IDLE;
      @(posedge hclk);
      @(negedge hclk);
      chk("t6_rst", {hreadyout, hresp, hrdata}, {1'b1, 1'b0, 32'h0});
      hreset   = 1'b0;
      q.delete();
      a_ph     = mk(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
      d_ph     = a_ph;
      prev_rdy = 1'b1;
      push(0, 0, 32'h40, HSIZE_WORD, 32'h0, 0);
      drain();
      chk("t6_old", last_rdata, old);

      for (int k = 0; k < 600; k++) begin
         bit w;
         bit s;
         logic [2:0] sz;
         logic [31:0] a;
         int r;
         w  = 1'($urandom_range(0, 1));
         s  = 1'($urandom_range(0, 1));
         sz = 3'($urandom_range(0, 2));
         if ($urandom_range(0, 15) == 0) sz = 3'($urandom_range(3, 7));
         a  = $urandom_range(0, 'h3FF);
         r  = $urandom_range(0, 31);
         if (r > 2) a = a & ~((32'd1 << sz) - 32'd1);
         if (r == 0) a = MS + $urandom_range(0, 'hFFFF);
         push(w, s, a, sz, $urandom(), $urandom_range(0, 19) == 0);
         if ($urandom_range(0, 3) == 0) begin
            q.push_back(mk(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0));
         end
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
